// File: rtl/htif_mailbox.sv
// htif_mailbox: HTIF-style tohost/fromhost mailbox between a core-side request
// port and a host. Offsets: 0 TOHOST, 1 FROMHOST (read-to-clear), 2 STATUS,
// 3 WDOG_LIMIT. The watchdog (counter, limit register, interrupt) is built only
// when the macro MAILBOX_WDOG_EN is defined; otherwise interrupt is tied low.
module htif_mailbox (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic [63:0] tohost,
  output logic        tohost_valid,
  input  logic        host_ack,
  input  logic        fromhost_valid,
  output logic        fromhost_ready,
  input  logic [63:0] fromhost_data,
  output logic        interrupt
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_RESP     = 2'd2
  } state_t;

  localparam logic [1:0]  ADDR_TOHOST   = 2'd0;
  localparam logic [1:0]  ADDR_FROMHOST = 2'd1;
  localparam logic [1:0]  ADDR_STATUS   = 2'd2;
  localparam logic [1:0]  ADDR_LIMIT    = 2'd3;

  state_t      state_r;
  state_t      state_next_s;
  logic [63:0] tohost_r;
  logic        tohost_pending_r;
  logic [63:0] hold_r;
  logic [63:0] fromhost_r;
  logic        fromhost_pending_r;
  logic        resp_valid_r;
  logic [63:0] resp_rdata_r;
  logic [63:0] rd_data_s;
  logic        req_ready_s;
  logic        fromhost_ready_s;
  logic        accept_s;
  logic        tohost_wr_s;
  logic        ack_hit_s;
  logic        tohost_stall_s;
  logic        fh_push_s;
  logic        fh_read_s;
  logic        wdog_expired_s;
  logic [31:0] wdog_limit_s;

  assign accept_s       = req_valid && req_ready_s;
  assign tohost_wr_s    = accept_s && req_write && (req_addr == ADDR_TOHOST);
  // An ack in WAIT_ACK releases the parked write instead of clearing the mailbox.
  assign ack_hit_s      = host_ack && tohost_pending_r && (state_r != ST_WAIT_ACK);
  // A TOHOST write stalls only if the mailbox stays full after this cycle's ack.
  assign tohost_stall_s = tohost_wr_s && tohost_pending_r && !ack_hit_s;
  assign fh_push_s      = fromhost_valid && fromhost_ready_s;
  assign fh_read_s      = accept_s && !req_write && (req_addr == ADDR_FROMHOST);

  // State register: reset forces IDLE from any state, dropping a pending response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic for the request/response handshake.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (tohost_stall_s) begin
            state_next_s = ST_WAIT_ACK;
          end else begin
            state_next_s = ST_RESP;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT_ACK: begin
        if (host_ack) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_WAIT_ACK;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode: both ready signals are held low while reset is asserted.
  always_comb begin
    req_ready_s      = 1'b0;
    fromhost_ready_s = 1'b0;
    if (reset) begin
      req_ready_s      = 1'b0;
      fromhost_ready_s = 1'b0;
    end else begin
      req_ready_s      = (state_r == ST_IDLE);
      fromhost_ready_s = !fromhost_pending_r;
    end
  end

  // Read mux from pre-edge register values; writes respond with zero.
  always_comb begin
    rd_data_s = 64'd0;
    if (req_write) begin
      rd_data_s = 64'd0;
    end else begin
      case (req_addr)
        ADDR_TOHOST:   rd_data_s = tohost_r;
        ADDR_FROMHOST: rd_data_s = fromhost_pending_r ? fromhost_r : 64'd0;
        ADDR_STATUS:   rd_data_s = {61'd0, wdog_expired_s, fromhost_pending_r, tohost_pending_r};
        ADDR_LIMIT:    rd_data_s = {32'd0, wdog_limit_s};
        default:       rd_data_s = 64'd0;
      endcase
    end
  end

  // Response register: loaded on acceptance or on WAIT_ACK release, held until taken.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 64'd0;
    end else if ((state_r == ST_IDLE) && accept_s && !tohost_stall_s) begin
      resp_valid_r <= 1'b1;
      resp_rdata_r <= rd_data_s;
    end else if ((state_r == ST_WAIT_ACK) && host_ack) begin
      resp_valid_r <= 1'b1;
      resp_rdata_r <= 64'd0;
    end else if ((state_r == ST_RESP) && resp_ready) begin
      resp_valid_r <= 1'b0;
    end
  end

  // TOHOST mailbox: ack is applied before a same-cycle write; stalled writes park in hold_r.
  always_ff @(posedge clock) begin
    if (reset) begin
      tohost_r         <= 64'd0;
      tohost_pending_r <= 1'b0;
      hold_r           <= 64'd0;
    end else if ((state_r == ST_WAIT_ACK) && host_ack) begin
      tohost_r         <= hold_r;
      tohost_pending_r <= 1'b1;
    end else begin
      if (tohost_wr_s && !tohost_stall_s) begin
        tohost_r         <= req_wdata;
        tohost_pending_r <= 1'b1;
      end else if (ack_hit_s) begin
        tohost_r         <= 64'd0;
        tohost_pending_r <= 1'b0;
      end
      if (tohost_stall_s) begin
        hold_r <= req_wdata;
      end
    end
  end

  // FROMHOST mailbox: host push when empty, cleared by a core read.
  always_ff @(posedge clock) begin
    if (reset) begin
      fromhost_r         <= 64'd0;
      fromhost_pending_r <= 1'b0;
    end else if (fh_push_s) begin
      fromhost_r         <= fromhost_data;
      fromhost_pending_r <= 1'b1;
    end else if (fh_read_s) begin
      fromhost_r         <= 64'd0;
      fromhost_pending_r <= 1'b0;
    end
  end

`ifdef MAILBOX_WDOG_EN
  logic [31:0] wdog_cnt_r;
  logic [31:0] wdog_limit_r;
  logic        wdog_expired_r;
  logic        status_w1c_s;
  logic        limit_wr_s;

  assign status_w1c_s = accept_s && req_write && (req_addr == ADDR_STATUS) && req_wdata[2];
  assign limit_wr_s   = accept_s && req_write && (req_addr == ADDR_LIMIT);

  // Watchdog: saturating counter kicked by TOHOST writes; sticky expiry cleared by W1C.
  always_ff @(posedge clock) begin
    if (reset) begin
      wdog_cnt_r     <= 32'd0;
      wdog_limit_r   <= 32'd50000;
      wdog_expired_r <= 1'b0;
    end else begin
      if (limit_wr_s) begin
        wdog_limit_r <= req_wdata[31:0];
      end
      if (status_w1c_s) begin
        wdog_cnt_r     <= 32'd0;
        wdog_expired_r <= 1'b0;
      end else begin
        if (wdog_cnt_r >= wdog_limit_r) begin
          wdog_expired_r <= 1'b1;
        end
        if (tohost_wr_s) begin
          wdog_cnt_r <= 32'd0;
        end else if (wdog_cnt_r != 32'hFFFF_FFFF) begin
          wdog_cnt_r <= wdog_cnt_r + 32'd1;
        end
      end
    end
  end

  assign wdog_expired_s = wdog_expired_r;
  assign wdog_limit_s   = wdog_limit_r;
  assign interrupt      = wdog_expired_r;
`else
  assign wdog_expired_s = 1'b0;
  assign wdog_limit_s   = 32'd0;
  assign interrupt      = 1'b0;
`endif

  assign req_ready      = req_ready_s;
  assign fromhost_ready = fromhost_ready_s;
  assign resp_valid     = resp_valid_r;
  assign resp_rdata     = resp_rdata_r;
  assign tohost         = tohost_r;
  assign tohost_valid   = tohost_pending_r;

endmodule

// File: tb/tb_htif_mailbox.sv
// tb_htif_mailbox: directed scenarios plus randomized traffic against a
// transaction-level mailbox model; expected responses go through a scoreboard.
module tb_htif_mailbox;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_addr = 2'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic [63:0] tohost;
  logic        tohost_valid;
  logic        host_ack = 1'b0;
  logic        fromhost_valid = 1'b0;
  logic        fromhost_ready;
  logic [63:0] fromhost_data = 64'd0;
  logic        interrupt;

  htif_mailbox dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .tohost(tohost), .tohost_valid(tohost_valid), .host_ack(host_ack),
    .fromhost_valid(fromhost_valid), .fromhost_ready(fromhost_ready),
    .fromhost_data(fromhost_data), .interrupt(interrupt)
  );

`ifdef MAILBOX_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_RESP = 2;

  // Reference model state
  int          m_state = M_IDLE;
  logic [63:0] m_tohost = 64'd0;
  logic        m_tpend = 1'b0;
  logic [63:0] m_hold = 64'd0;
  logic [63:0] m_fh = 64'd0;
  logic        m_fpend = 1'b0;
  logic [31:0] m_cnt = 32'd0;
  logic [31:0] m_lim = 32'd50000;
  logic        m_exp = 1'b0;
  logic [63:0] exp_q[$];

  int n_checks = 0;
  int n_fail = 0;

  initial forever #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    chk(name, {63'd0, act}, {63'd0, req});
  endtask

  // Model of one clock edge, applied to the inputs present at that edge.
  task automatic model_step();
    logic        acc;
    logic        push;
    logic        ack_hit;
    logic [63:0] rd;
    if (reset) begin
      m_state = M_IDLE; m_tohost = 64'd0; m_tpend = 1'b0; m_hold = 64'd0;
      m_fh = 64'd0; m_fpend = 1'b0; m_cnt = 32'd0; m_lim = 32'd50000; m_exp = 1'b0;
      exp_q.delete();
      return;
    end
    acc  = req_valid && (m_state == M_IDLE);
    push = fromhost_valid && !m_fpend;
    rd   = 64'd0;
    if (acc && !req_write) begin
      case (req_addr)
        2'd0:    rd = m_tohost;
        2'd1:    rd = m_fh;
        2'd2:    rd = {61'd0, m_exp, m_fpend, m_tpend};
        default: rd = WDOG_ON ? {32'd0, m_lim} : 64'd0;
      endcase
    end
    if (WDOG_ON) begin
      if (acc && req_write && req_addr == 2'd2 && req_wdata[2]) begin
        m_cnt = 32'd0;
        m_exp = 1'b0;
      end else begin
        if (m_cnt >= m_lim) m_exp = 1'b1;
        if (acc && req_write && req_addr == 2'd0) m_cnt = 32'd0;
        else if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end
      if (acc && req_write && req_addr == 2'd3) m_lim = req_wdata[31:0];
    end
    ack_hit = host_ack && m_tpend && (m_state != M_WAIT);
    if (m_state == M_WAIT && host_ack) begin
      m_tohost = m_hold;
      m_state  = M_RESP;
    end else if (m_state == M_RESP && resp_ready) begin
      m_state = M_IDLE;
    end
    if (ack_hit) begin
      m_tohost = 64'd0;
      m_tpend  = 1'b0;
    end
    if (acc) begin
      exp_q.push_back(rd);
      if (req_write && req_addr == 2'd0) begin
        if (m_tpend) begin
          m_hold  = req_wdata;
          m_state = M_WAIT;
        end else begin
          m_tohost = req_wdata;
          m_tpend  = 1'b1;
          m_state  = M_RESP;
        end
      end else begin
        m_state = M_RESP;
        if (!req_write && req_addr == 2'd1) begin
          m_fh    = 64'd0;
          m_fpend = 1'b0;
        end
      end
    end
    if (push) begin
      m_fh    = fromhost_data;
      m_fpend = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // Monitor: compares DUT outputs with the model on each falling edge.
  initial begin
    logic [63:0] e;
    @(posedge clock);
    forever begin
      @(negedge clock);
      chk1("req_ready", req_ready, !reset && (m_state == M_IDLE));
      chk1("fromhost_ready", fromhost_ready, !reset && !m_fpend);
      chk("tohost", tohost, m_tohost);
      chk1("tohost_valid", tohost_valid, m_tpend);
      chk1("interrupt", interrupt, m_exp);
      chk1("resp_valid", resp_valid, m_state == M_RESP);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 64'd1, 64'd0);
        end else begin
          chk("resp_rdata", resp_rdata, exp_q[0]);
          if (resp_ready && !reset) e = exp_q.pop_front();
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_req(input logic wr, input logic [1:0] a, input logic [63:0] d);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0; req_write = 1'b0; req_wdata = 64'd0;
  endtask

  task automatic take_resp();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk1("reset_req_ready", req_ready, 1'b0);
    chk1("reset_fh_ready", fromhost_ready, 1'b0);
    chk("reset_tohost", tohost, 64'd0);
    chk1("reset_resp_valid", resp_valid, 1'b0);
    reset = 1'b0;
    tick();
    chk1("idle_req_ready", req_ready, 1'b1);

    // Write to an empty TOHOST
    do_req(1'b1, 2'd0, 64'h1);
    chk("t1_tohost", tohost, 64'h1);
    chk1("t1_tvalid", tohost_valid, 1'b1);
    chk1("t1_resp", resp_valid, 1'b1);
    chk("t1_rdata", resp_rdata, 64'd0);
    take_resp();

    // Write to a full TOHOST, ack five edges after acceptance
    do_req(1'b1, 2'd0, 64'h3);
    chk1("t2_resp_hold0", resp_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("t2_resp_hold", resp_valid, 1'b0);
    end
    chk("t2_old_tohost", tohost, 64'h1);
    host_ack = 1'b1;
    tick();
    host_ack = 1'b0;
    chk1("t2_resp", resp_valid, 1'b1);
    chk("t2_tohost", tohost, 64'h3);
    chk1("t2_tvalid", tohost_valid, 1'b1);
    take_resp();

    // Same-cycle ack and write loads directly
    host_ack = 1'b1;
    do_req(1'b1, 2'd0, 64'h5);
    host_ack = 1'b0;
    chk("t3_tohost", tohost, 64'h5);
    chk1("t3_resp", resp_valid, 1'b1);
    take_resp();
    host_ack = 1'b1;
    tick();
    host_ack = 1'b0;
    chk("t3_cleared", tohost, 64'd0);
    chk1("t3_tvalid", tohost_valid, 1'b0);

    // FROMHOST push and read-to-clear
    fromhost_valid = 1'b1; fromhost_data = 64'hDEAD;
    tick();
    fromhost_valid = 1'b0; fromhost_data = 64'd0;
    chk1("t4_fh_ready_busy", fromhost_ready, 1'b0);
    tick();
    chk1("t4_fh_ready_busy2", fromhost_ready, 1'b0);
    do_req(1'b0, 2'd2, 64'd0);
    chk("t4_status", resp_rdata, 64'h2);
    take_resp();
    do_req(1'b0, 2'd1, 64'd0);
    chk("t4_read1", resp_rdata, 64'hDEAD);
    chk1("t4_fh_ready_free", fromhost_ready, 1'b1);
    take_resp();
    do_req(1'b0, 2'd1, 64'd0);
    chk("t4_read2", resp_rdata, 64'd0);
    take_resp();

    // Reset in WAIT_ACK
    do_req(1'b1, 2'd0, 64'h7);
    take_resp();
    do_req(1'b1, 2'd0, 64'h9);
    tick();
    reset = 1'b1;
    tick();
    chk1("t5_resp", resp_valid, 1'b0);
    chk("t5_tohost", tohost, 64'd0);
    chk1("t5_tvalid", tohost_valid, 1'b0);
    chk1("t5_req_ready", req_ready, 1'b0);
    chk1("t5_fh_ready", fromhost_ready, 1'b0);
    reset = 1'b0;
    tick();
    chk1("t5_idle", req_ready, 1'b1);

`ifdef MAILBOX_WDOG_EN
    do_req(1'b1, 2'd3, 64'd10);
    take_resp();
    repeat (14) tick();
    chk1("t6_irq", interrupt, 1'b1);
    do_req(1'b1, 2'd2, 64'h4);
    chk1("t6_irq_clr", interrupt, 1'b0);
    take_resp();
`else
    do_req(1'b1, 2'd3, 64'd123);
    take_resp();
    do_req(1'b0, 2'd3, 64'd0);
    chk("t6_limit_rd", resp_rdata, 64'd0);
    take_resp();
    do_req(1'b0, 2'd2, 64'd0);
    chk("t6_status_rd", resp_rdata, 64'd0);
    take_resp();
    chk1("t6_irq", interrupt, 1'b0);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      req_valid      = ($urandom_range(0, 2) == 0);
      req_write      = 1'($urandom_range(0, 1));
      req_addr       = 2'($urandom_range(0, 3));
      req_wdata      = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 40));
      resp_ready     = ($urandom_range(0, 3) != 0);
      host_ack       = ($urandom_range(0, 5) == 0);
      fromhost_valid = ($urandom_range(0, 3) == 0);
      fromhost_data  = {$urandom, $urandom};
      reset          = ($urandom_range(0, 499) == 0);
      tick();
    end

    // Drain outstanding transactions within a bounded number of cycles
    req_valid = 1'b0; reset = 1'b0; fromhost_valid = 1'b0;
    resp_ready = 1'b1; host_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (m_state != M_IDLE) tick();
    end
    host_ack = 1'b0; resp_ready = 1'b0;
    tick();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    chk1("end_idle", req_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/htif_mailbox.md
HTIF_MAILBOX -- requirements
Module: htif_mailbox

Interface
REQ-001 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports req_valid/req_ready  input/output  1/1  DUT-side request handshake.
REQ-004 SHALL have ports req_write  input  1, req_addr  input  2, req_wdata  input  64  write flag, word offset, write data.
REQ-005 SHALL have ports resp_valid/resp_ready  output/input  1/1, resp_rdata  output  64  response handshake and read data.
REQ-006 SHALL have ports tohost  output  64, tohost_valid  output  1, host_ack  input  1  host-side tohost mailbox.
REQ-007 SHALL have ports fromhost_valid  input  1, fromhost_ready  output  1, fromhost_data  input  64  host-side fromhost push.
REQ-008 SHALL have port interrupt  output  1  watchdog expiry to core.

Function
REQ-009 SHALL decode offsets: 0 TOHOST (RW), 1 FROMHOST (R, read-to-clear; writes ignored), 2 STATUS (bit0 tohost_pending, bit1 fromhost_pending, bit2 wdog_expired), 3 WDOG_LIMIT (RW, 32 bits, zero-extended).
REQ-010 SHALL implement FSM IDLE, WAIT_ACK, RESP; req_ready=1 only in IDLE.
REQ-011 SHALL, on accepted request, enter RESP next cycle with resp_valid=1 and resp_rdata valid, except REQ-013; latency 1 cycle.
REQ-012 SHALL hold resp_valid and resp_rdata stable in RESP until resp_ready=1, then return to IDLE same edge; resp_rdata=0 for writes.
REQ-013 SHALL, on TOHOST write with tohost_pending=1 and no host_ack that cycle, latch wdata and enter WAIT_ACK; on host_ack in WAIT_ACK, load latched data into tohost, keep pending=1, enter RESP.
REQ-014 SHALL, on TOHOST write with pending=0, load tohost and set pending=1 on the acceptance edge.
REQ-015 SHALL, on host_ack with pending=1 in IDLE/RESP, clear tohost to 0 and pending to 0; host_ack with pending=0 ignored.
REQ-016 SHALL evaluate host_ack before a same-cycle TOHOST write: the write then loads directly per REQ-014.
REQ-017 SHALL drive tohost_valid=tohost_pending and fromhost_ready=!fromhost_pending.
REQ-018 SHALL capture fromhost_data and set fromhost_pending when fromhost_valid && fromhost_ready.
REQ-019 SHALL, on accepted FROMHOST read, return the register and clear it and fromhost_pending on the acceptance edge; read with pending=0 returns 0.
REQ-020 SHALL allow back-to-back requests only after resp handshake; no request queueing.

Reset
REQ-021 SHALL, on reset=1 at any state (incl. WAIT_ACK/RESP mid-transaction), go to IDLE and drop any pending response.
REQ-022 SHALL reset tohost=0, tohost_valid=0, fromhost register=0, fromhost_pending=0, resp_valid=0, resp_rdata=0, interrupt=0, watchdog counter=0, wdog_expired=0, WDOG_LIMIT=50000.
REQ-023 SHALL drive req_ready=0 and fromhost_ready=1 during reset... superseded: req_ready=0 and fromhost_ready=0 while reset=1.

Configuration
REQ-024 SHALL compile watchdog logic only when macro MAILBOX_WDOG_EN is defined.
REQ-025 SHALL, with MAILBOX_WDOG_EN: 32-bit counter increments each non-reset cycle, saturates, clears on accepted TOHOST write; when counter >= WDOG_LIMIT set sticky wdog_expired; interrupt=wdog_expired.
REQ-026 SHALL, with MAILBOX_WDOG_EN: STATUS write with wdata bit2=1 clears wdog_expired and counter (W1C); WDOG_LIMIT=0 means expiry next cycle.
REQ-027 SHALL, without MAILBOX_WDOG_EN: interrupt tied 0, STATUS bit2 reads 0, offset 3 reads 0, writes to offsets 2/3 ignored.

Verification
REQ-028 SHALL cover: write TOHOST=0x1 (pending=0) -> tohost=0x1, tohost_valid=1 next edge, resp_valid=1 one cycle after acceptance.
REQ-029 SHALL cover: write TOHOST=0x3 while tohost=0x1 pending, host_ack 5 cycles later -> resp withheld 5 cycles, then tohost=0x3, tohost_valid=1.
REQ-030 SHALL cover: host pushes 0xDEAD, DUT reads offset 1 twice -> 0xDEAD then 0x0; fromhost_ready 0 between push and first read.
REQ-031 SHALL cover: host_ack and TOHOST write 0x5 same cycle with pending -> tohost=0x5 directly, no WAIT_ACK.
REQ-032 SHALL cover (MAILBOX_WDOG_EN): WDOG_LIMIT=10, no TOHOST writes -> interrupt=1 after 10 cycles; STATUS write 0x4 -> interrupt=0.
REQ-033 SHALL cover: reset asserted in WAIT_ACK -> next edge FSM IDLE, resp_valid=0, tohost=0, tohost_valid=0.
